// File: rtl/branch_tag_ctrl.sv
// Branch tag allocator: ring of BR_DEPTH slots, in-order free/rollback, any-order resolve.
// Optional macro BR_FORWARD_RES_EN lets a head resolution free/roll back in the same cycle.

module branch_tag_slot (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic free,
    input  logic alloc,
    input  logic resolve,
    input  logic resMis,
    output logic vld,
    output logic res,
    output logic mis
);
    // Clearing wins over a same-cycle resolve of the freed head slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
            res <= 1'b0;
            mis <= 1'b0;
        end else if (clr || free) begin
            vld <= 1'b0;
            res <= 1'b0;
            mis <= 1'b0;
        end else if (alloc) begin
            vld <= 1'b1;
            res <= 1'b0;
            mis <= 1'b0;
        end else if (resolve) begin
            res <= 1'b1;
            mis <= resMis;
        end
    end
endmodule

module branch_tag_ctrl #(
    parameter int BR_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          decBrValid,
    output logic                          decBrReady,
    output logic [BR_DEPTH-1:0]           brTagOut,
    input  logic                          resValid,
    input  logic [BR_DEPTH-1:0]           resTag,
    input  logic                          resMis,
    output logic                          branchDeeper,
    output logic                          bFreeEn,
    output logic                          misTaken,
    output logic [BR_DEPTH-1:0]           brMask,
    output logic [$clog2(BR_DEPTH+1)-1:0] brCount
);
    localparam int CW = $clog2(BR_DEPTH+1);
    localparam int PW = (BR_DEPTH > 1) ? $clog2(BR_DEPTH) : 1;

    logic [PW-1:0]       head, tail;
    logic [BR_DEPTH-1:0] vld, res, mis;
    logic [BR_DEPTH-1:0] headOh, tailOh, freeVec, allocVec, resVec;
    logic [CW-1:0]       cnt;
    logic                resOneHot, resHit, fwdHit, headRes, headMis, alloc;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BR_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        headOh    = BR_DEPTH'(1) << head;
        tailOh    = BR_DEPTH'(1) << tail;
        resOneHot = (resTag != '0) && ((resTag & (resTag - BR_DEPTH'(1))) == '0);
        resHit    = resValid && resOneHot && ((resTag & vld & ~res) != '0);
`ifdef BR_FORWARD_RES_EN
        fwdHit    = resHit && ((resTag & headOh) != '0);
`else
        fwdHit    = 1'b0;
`endif
        headRes   = ((vld & res & headOh) != '0) || fwdHit;
        headMis   = ((vld & res & mis & headOh) != '0) || (fwdHit && resMis);
        misTaken  = rst && headRes && headMis;
        bFreeEn   = rst && headRes && !headMis;
        cnt = '0;
        for (int i = 0; i < BR_DEPTH; i++) cnt = cnt + CW'(vld[i]);
        // Ready looks at the registered count, so a same-cycle free never admits a full-ring alloc.
        decBrReady   = rst && (cnt < CW'(BR_DEPTH)) && (mis == '0) && !misTaken;
        alloc        = decBrValid && decBrReady;
        branchDeeper = alloc;
        brTagOut     = alloc ? tailOh : '0;
        allocVec     = alloc ? tailOh : '0;
        freeVec      = bFreeEn ? headOh : '0;
        resVec       = (resHit && !misTaken) ? resTag : '0;
    end

    assign brMask  = vld;
    assign brCount = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (misTaken) begin
            tail <= head;
        end else begin
            if (bFreeEn) head <= nxt(head);
            if (alloc)   tail <= nxt(tail);
        end
    end

    for (genvar i = 0; i < BR_DEPTH; i++) begin : g_slot
        branch_tag_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (misTaken),
            .free    (freeVec[i]),
            .alloc   (allocVec[i]),
            .resolve (resVec[i]),
            .resMis  (resMis),
            .vld     (vld[i]),
            .res     (res[i]),
            .mis     (mis[i])
        );
    end
endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed bench for branch_tag_ctrl (BR_DEPTH=3); BR_FORWARD_RES_EN selects the forwarding scenario.
module tb_branch_tag_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       decBrValid = 1'b0;
    logic       decBrReady;
    logic [2:0] brTagOut;
    logic       resValid = 1'b0;
    logic [2:0] resTag = 3'b000;
    logic       resMis = 1'b0;
    logic       branchDeeper, bFreeEn, misTaken;
    logic [2:0] brMask;
    logic [1:0] brCount;

    int vecs = 0;
    int errs = 0;

    branch_tag_ctrl #(.BR_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .decBrValid(decBrValid), .decBrReady(decBrReady),
        .brTagOut(brTagOut), .resValid(resValid), .resTag(resTag), .resMis(resMis),
        .branchDeeper(branchDeeper), .bFreeEn(bFreeEn), .misTaken(misTaken),
        .brMask(brMask), .brCount(brCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res_set(input logic v, input logic [2:0] t, input logic m);
        resValid = v;
        resTag   = t;
        resMis   = m;
    endtask

    initial begin
        // Reset state, with a request pending to prove it is refused.
        decBrValid = 1'b1;
        #2;
        chk("rst_ready", decBrReady, 0);
        chk("rst_deeper", branchDeeper, 0);
        chk("rst_tag", brTagOut, 0);
        chk("rst_mask", brMask, 0);
        chk("rst_count", brCount, 0);
        chk("rst_free", bFreeEn, 0);
        chk("rst_mis", misTaken, 0);
        decBrValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Three allocations
        decBrValid = 1'b1;
        #1; chk("a0_tag", brTagOut, 3'b001); chk("a0_deeper", branchDeeper, 1);
        tick();
        #1; chk("a1_tag", brTagOut, 3'b010);
        tick();
        #1; chk("a2_tag", brTagOut, 3'b100);
        tick();
        #1;
        chk("full_count", brCount, 3);
        chk("full_ready", decBrReady, 0);
        chk("full_deeper", branchDeeper, 0);
        chk("full_tag", brTagOut, 0);
        chk("full_mask", brMask, 3'b111);
        decBrValid = 1'b0;

`ifdef BR_FORWARD_RES_EN
        res_set(1, 3'b001, 0);
        #1; chk("fwd_free", bFreeEn, 1); chk("fwd_nomis", misTaken, 0);
        tick();
        res_set(1, 3'b010, 1);
        #1;
        chk("fwd_count", brCount, 2);
        chk("fwd_mask", brMask, 3'b110);
        chk("fwd_mis", misTaken, 1);
        chk("fwd_mis_nofree", bFreeEn, 0);
        tick();
        res_set(0, 3'b000, 0);
        #1;
        chk("fwd_rb_count", brCount, 0);
        chk("fwd_rb_ready", decBrReady, 1);
        decBrValid = 1'b1;
        #1; chk("fwd_rb_tag", brTagOut, 3'b010);
        tick();
        decBrValid = 1'b0;
`else
        // Out-of-order resolve, in-order free
        res_set(1, 3'b010, 0);
        #1; chk("ooo_nofree", bFreeEn, 0);
        tick();
        res_set(1, 3'b001, 0);
        #1; chk("head_res_delay", bFreeEn, 0);
        tick();
        res_set(0, 3'b000, 0);
        #1; chk("free0", bFreeEn, 1); chk("free0_count", brCount, 3);
        tick();
        // Free and allocate together: count holds at 2
        decBrValid = 1'b1;
        #1;
        chk("free1", bFreeEn, 1);
        chk("free1_count", brCount, 2);
        chk("af_tag", brTagOut, 3'b001);
        tick();
        decBrValid = 1'b0;
        // Mispredict on the younger, non-head slot 001 (head is 100)
        res_set(1, 3'b001, 1);
        #1; chk("af_count", brCount, 2); chk("af_mask", brMask, 3'b101);
        tick();
        decBrValid = 1'b1;
        res_set(1, 3'b100, 0);
        #1;
        chk("pend_ready", decBrReady, 0);
        chk("pend_deeper", branchDeeper, 0);
        chk("pend_nomis", misTaken, 0);
        tick();
        decBrValid = 1'b0;
        res_set(0, 3'b000, 0);
        #1; chk("pend_free", bFreeEn, 1); chk("pend_free_nomis", misTaken, 0);
        tick();
        decBrValid = 1'b1;
        #1;
        chk("rb_mis", misTaken, 1);
        chk("rb_nofree", bFreeEn, 0);
        chk("rb_deeper", branchDeeper, 0);
        chk("rb_count", brCount, 1);
        tick();
        #1;
        chk("rb_after_count", brCount, 0);
        chk("rb_after_ready", decBrReady, 1);
        chk("rb_after_tag", brTagOut, 3'b001);
        tick();
        decBrValid = 1'b0;
        // Ignored resolutions: not one-hot, then invalid slot
        res_set(1, 3'b011, 1);
        #1; chk("ign_count", brCount, 1);
        tick();
        res_set(1, 3'b100, 1);
        tick();
        res_set(1, 3'b001, 0);
        #1;
        chk("ign_nomis", misTaken, 0);
        chk("ign_nofree", bFreeEn, 0);
        chk("ign_ready", decBrReady, 1);
        tick();
        res_set(0, 3'b000, 0);
        #1; chk("ign_free", bFreeEn, 1);
        tick();
        // Wrap: head=tail=1
        decBrValid = 1'b1;
        #1; chk("w0_tag", brTagOut, 3'b010);
        tick();
        #1; chk("w1_tag", brTagOut, 3'b100);
        tick();
        #1; chk("w2_tag", brTagOut, 3'b001);
        tick();
        decBrValid = 1'b0;
        res_set(1, 3'b010, 0);
        tick();
        // Full with head freeing: no allocation this cycle
        res_set(0, 3'b000, 0);
        decBrValid = 1'b1;
        #1;
        chk("ff_free", bFreeEn, 1);
        chk("ff_deeper", branchDeeper, 0);
        chk("ff_tag", brTagOut, 0);
        tick();
        #1;
        chk("ff_next_deeper", branchDeeper, 1);
        chk("ff_next_tag", brTagOut, 3'b010);
        tick();
        decBrValid = 1'b0;
        #1; chk("ff_count", brCount, 3);
`endif

        // Asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        chk("arst_mask", brMask, 0);
        chk("arst_count", brCount, 0);
        chk("arst_ready", decBrReady, 0);
        decBrValid = 1'b1;
        #1;
        chk("arst_deeper", branchDeeper, 0);
        chk("arst_tag", brTagOut, 0);
        decBrValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        decBrValid = 1'b1;
        #1; chk("post_tag", brTagOut, 3'b001); chk("post_ready", decBrReady, 1);
        tick();
        decBrValid = 1'b0;
        #1; chk("post_count", brCount, 1); chk("post_mask", brMask, 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/branch_tag_ctrl.md
BRANCH_TAG_CTRL -- requirements
Module: branch_tag_ctrl

Interface
REQ-001 The block SHALL have parameter BR_DEPTH, default 3, giving the maximum number of outstanding branches (the register-file line stack holds BR_DEPTH+1 snapshots).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset; state clears while low, independent of clk.
- decBrValid  in  1  decoder presents a branch for tag allocation.
- decBrReady  out  1  allocation is accepted this cycle.
- brTagOut  out  BR_DEPTH  one-hot tag of the slot allocated this cycle.
- resValid  in  1  branch unit resolves a branch.
- resTag  in  BR_DEPTH  one-hot tag being resolved.
- resMis  in  1  resolved branch was mispredicted.
- branchDeeper  out  1  pulse to the register file: new snapshot level.
- bFreeEn  out  1  pulse to the register file: oldest level is now reliable.
- misTaken  out  1  pulse to the register file and pipeline: roll back to the reliable level.
- brMask  out  BR_DEPTH  slots currently outstanding.
- brCount  out  $clog2(BR_DEPTH+1)  number of outstanding branches.

Function
REQ-003 The block SHALL keep a ring of BR_DEPTH slots with head (oldest) and tail (next free) pointers; each slot holds valid, resolved and mis bits.
REQ-004 Pointers SHALL wrap from BR_DEPTH-1 to 0.
REQ-005 decBrReady SHALL equal (brCount < BR_DEPTH) AND no slot has mis set AND misTaken low.
REQ-006 On decBrValid and decBrReady, branchDeeper SHALL be high in the same cycle; brTagOut SHALL be one-hot at tail; at the clock edge the slot is set valid with resolved and mis clear, and tail advances.
REQ-007 brTagOut SHALL be 0 when no allocation occurs.
REQ-008 On resValid, if resTag selects a valid, unresolved slot, that slot SHALL latch resolved=1 and mis=resMis; any other resTag (not valid, already resolved, not one-hot) SHALL be ignored.
REQ-009 Resolutions SHALL be accepted in any order; frees and rollbacks SHALL be issued strictly in head order.
REQ-010 When the head slot is valid, resolved and not mis, bFreeEn SHALL be high for that cycle; at the edge the slot is cleared and head advances. At most one free per cycle.
REQ-011 When the head slot is valid, resolved and mis, misTaken SHALL be high for that cycle; at the edge all slots are cleared, tail is set to head, and brCount becomes 0.
REQ-012 bFreeEn and misTaken SHALL never be high together.
REQ-013 branchDeeper SHALL never be high in a cycle where misTaken is high.
REQ-014 A mispredict recorded on a non-head slot SHALL be held, and SHALL block new allocations, until all older branches free and it reaches head.
REQ-015 Allocation and free in the same cycle SHALL both take effect; brCount is unchanged.
REQ-016 Allocation when full SHALL NOT occur, even if a free happens in that cycle, because ready uses the registered count.
REQ-017 A resolution arriving in a misTaken cycle SHALL be discarded.
REQ-018 brMask SHALL equal the registered valid bits; brCount SHALL equal their population.

Reset
REQ-019 While rst is low: all slots invalid, head=tail=0, brCount=0, brMask=0, decBrReady=0, branchDeeper=bFreeEn=misTaken=0, brTagOut=0.
REQ-020 Reset asserted mid-operation SHALL discard all outstanding and pending-mispredict state immediately; the first allocation after release SHALL get tag 1 (slot 0).

Configuration
REQ-021 With BR_FORWARD_RES_EN defined, a resolution whose resTag selects the valid head slot SHALL produce bFreeEn or misTaken combinationally in the same cycle. Without the macro, the response SHALL come one cycle after resValid.

Verification
REQ-022 The bench SHALL cover these scenarios (macro undefined unless stated):
- Three allocations in cycles 0-2 -> brTagOut 001, 010, 100; brCount 3; decBrReady 0 in cycle 3.
- Resolve 010 (correct) at c5, then 001 (correct) at c6 -> bFreeEn high at c7 and c8; brMask 100 after c8.
- Slots 001, 010 outstanding; resolve 010 mis at c4 -> decBrReady 0 from c5; resolve 001 correct at c6 -> bFreeEn at c7, misTaken at c8, brCount 0 at c9.
- Full (count 3) with head free in same cycle as decBrValid -> no branchDeeper that cycle; allocation accepted next cycle with tag equal to freed slot.
- BR_FORWARD_RES_EN defined: resolve head 001 correct at c3 -> bFreeEn high at c3.
- rst driven low between clock edges with 2 outstanding -> outputs 0 immediately; after release, first allocation returns tag 001.
